// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state encoding and width helper for the reset sequencer
package rst_seq_pkg;

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_STAGE  = 2'd1,
    S_RUN    = 2'd2,
    S_ASSERT = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rst_sync2.sv
// rtl/rst_sync2.sv - two-flop synchronizer with asynchronous clear to a parameterised value
module rst_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - staged reset release for the VGA pipeline with lock-loss and soft re-sequencing
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int LOCK_CYC   = 32,
  parameter int STAGE_CYC  = 16,
  parameter int HOLD_CYC   = 8,
  parameter int CNT_W      = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               locked_in,
  input  logic                               soft_req,
  output logic [NUM_STAGES-1:0]              rst_out,
  output logic [clog2(NUM_STAGES+1)-1:0]     stage_idx,
  output logic                               seq_done,
  output logic                               busy
);

  localparam int IDX_W = clog2(NUM_STAGES + 1);
  localparam logic [CNT_W-1:0] LOCK_TC  = CNT_W'(LOCK_CYC - 1);
  localparam logic [CNT_W-1:0] STAGE_TC = CNT_W'(STAGE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  logic rel_n;
  logic int_rst;
  logic locked_s;

  // Internal reset asserts with the button and releases two edges after it falls.
  rst_sync2 #(.RESET_VAL(1'b0)) u_rst_sync (
    .clk (clk),
    .clr (reset),
    .d   (1'b1),
    .q   (rel_n)
  );

  assign int_rst = ~rel_n;

  rst_sync2 #(.RESET_VAL(1'b0)) u_lock_sync (
    .clk (clk),
    .clr (int_rst),
    .d   (locked_in),
    .q   (locked_s)
  );

  state_t                 state, state_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic [NUM_STAGES-1:0]  rst_nx;
  logic [IDX_W-1:0]       idx_nx;
  logic                   done_nx;
  logic                   busy_nx;
  logic                   abort;
  logic                   do_abort;

  assign abort = ~locked_s | soft_req;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rst_nx   = rst_out;
    idx_nx   = stage_idx;
    done_nx  = seq_done;
    busy_nx  = busy;
    do_abort = 1'b0;

    case (state)
      S_HOLD: begin
        rst_nx = '1;
        if (!locked_s) begin
          cnt_nx = '0;
        end else if (cnt == LOCK_TC) begin
          rst_nx[0] = 1'b0;
          idx_nx    = IDX_W'(1);
          cnt_nx    = '0;
          if (NUM_STAGES == 1) begin
            state_nx = S_RUN;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
          end else begin
            state_nx = S_STAGE;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      S_STAGE: begin
        if (abort) begin
          do_abort = 1'b1;
        end else if (cnt == STAGE_TC) begin
          for (int k = 0; k < NUM_STAGES; k++) begin
            if (IDX_W'(k) == stage_idx) rst_nx[k] = 1'b0;
          end
          idx_nx = stage_idx + 1'b1;
          cnt_nx = '0;
          if (stage_idx == LAST_IDX) begin
            state_nx = S_RUN;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      S_RUN: begin
        if (abort) do_abort = 1'b1;
      end

      S_ASSERT: begin
        // Any further abort event restarts the minimum hold window.
        if (abort) begin
          cnt_nx = '0;
        end else if (cnt == HOLD_TC) begin
          state_nx = S_HOLD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      default: begin
        state_nx = S_HOLD;
        cnt_nx   = '0;
      end
    endcase

    if (do_abort) begin
      state_nx = S_ASSERT;
      cnt_nx   = '0;
      rst_nx   = '1;
      idx_nx   = '0;
      done_nx  = 1'b0;
      busy_nx  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge int_rst) begin
    if (int_rst) begin
      state     <= S_HOLD;
      cnt       <= '0;
      rst_out   <= '1;
      stage_idx <= '0;
      seq_done  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rst_out   <= rst_nx;
      stage_idx <= idx_nx;
      seq_done  <= done_nx;
      busy      <= busy_nx;
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - directed self-checking bench for rst_sequencer (default and minimal configs)
module tb_rst_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       locked_in = 1'b1;
  logic       soft_req = 1'b0;
  logic       locked1 = 1'b1;
  logic       soft1 = 1'b0;

  logic [2:0] rst_out;
  logic [1:0] stage_idx;
  logic       seq_done;
  logic       busy;

  logic       rst_out1;
  logic       stage_idx1;
  logic       seq_done1;
  logic       busy1;

  int n_cmp = 0;
  int n_err = 0;
  int c;

  always #5 clk = ~clk;

  rst_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .locked_in (locked_in),
    .soft_req  (soft_req),
    .rst_out   (rst_out),
    .stage_idx (stage_idx),
    .seq_done  (seq_done),
    .busy      (busy)
  );

  rst_sequencer #(
    .NUM_STAGES (1),
    .LOCK_CYC   (1),
    .STAGE_CYC  (1),
    .HOLD_CYC   (1),
    .CNT_W      (8)
  ) dut1 (
    .clk       (clk),
    .reset     (reset),
    .locked_in (locked1),
    .soft_req  (soft1),
    .rst_out   (rst_out1),
    .stage_idx (stage_idx1),
    .seq_done  (seq_done1),
    .busy      (busy1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts clock edges until rst_out shows val; sampled on falling edges.
  task automatic wait_out(input logic [2:0] val, input int limit, output int cyc);
    cyc = 0;
    while (rst_out !== val && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    if (rst_out !== val) check_eq("timeout", 32'(rst_out), 32'(val));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    step(5);
    reset = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    step(5);
    check_eq("rst_out_rst", 32'(rst_out), 32'h7);
    check_eq("stage_idx_rst", 32'(stage_idx), 32'h0);
    check_eq("seq_done_rst", 32'(seq_done), 32'h0);
    check_eq("busy_rst", 32'(busy), 32'h1);
    check_eq("rst_out1_rst", 32'(rst_out1), 32'h1);
    check_eq("busy1_rst", 32'(busy1), 32'h1);
    reset = 1'b0;

    // Power-up: sync release (2) + lock sync (2) + 32, then 16, 16.
    wait_out(3'b110, 100, c);
    check_eq("pwr_rel0_cyc", 32'(c), 32'd36);
    check_eq("pwr_idx1", 32'(stage_idx), 32'd1);
    check_eq("pwr_busy1", 32'(busy), 32'd1);
    wait_out(3'b100, 40, c);
    check_eq("pwr_rel1_cyc", 32'(c), 32'd16);
    check_eq("pwr_idx2", 32'(stage_idx), 32'd2);
    wait_out(3'b000, 40, c);
    check_eq("pwr_rel2_cyc", 32'(c), 32'd16);
    check_eq("pwr_idx3", 32'(stage_idx), 32'd3);
    check_eq("pwr_done", 32'(seq_done), 32'd1);
    check_eq("pwr_busy0", 32'(busy), 32'd0);

    // One-cycle lock glitch in HOLD restarts the 32-cycle lock count.
    pulse_reset();
    step(24);
    locked_in = 1'b0;
    step(1);
    locked_in = 1'b1;
    wait_out(3'b110, 100, c);
    check_eq("glitch_rel0_cyc", 32'(c), 32'd34);
    wait_out(3'b000, 80, c);
    check_eq("glitch_done", 32'(seq_done), 32'd1);

    // Lock loss in RUN.
    locked_in = 1'b0;
    wait_out(3'b111, 10, c);
    check_eq("loss_assert_cyc", 32'(c), 32'd3);
    check_eq("loss_done0", 32'(seq_done), 32'd0);
    check_eq("loss_busy", 32'(busy), 32'd1);
    check_eq("loss_idx0", 32'(stage_idx), 32'd0);
    locked_in = 1'b1;
    wait_out(3'b110, 100, c);
    check_eq("loss_rel0_cyc", 32'(c), 32'd42);
    wait_out(3'b100, 40, c);
    check_eq("loss_rel1_cyc", 32'(c), 32'd16);
    wait_out(3'b000, 40, c);
    check_eq("loss_rel2_cyc", 32'(c), 32'd16);
    check_eq("loss_done1", 32'(seq_done), 32'd1);

    // Soft request in RUN, then in STAGE with an extending second pulse.
    soft_req = 1'b1;
    step(1);
    soft_req = 1'b0;
    check_eq("soft_run_out", 32'(rst_out), 32'h7);
    wait_out(3'b110, 100, c);
    check_eq("soft_run_rel0_cyc", 32'(c), 32'd40);
    wait_out(3'b100, 40, c);
    check_eq("soft_stage_at2", 32'(stage_idx), 32'd2);
    soft_req = 1'b1;
    step(1);
    soft_req = 1'b0;
    check_eq("soft_stage_out", 32'(rst_out), 32'h7);
    check_eq("soft_stage_idx", 32'(stage_idx), 32'd0);
    check_eq("soft_stage_busy", 32'(busy), 32'd1);
    step(4);
    soft_req = 1'b1;
    step(1);
    soft_req = 1'b0;
    wait_out(3'b110, 100, c);
    check_eq("soft_extend_rel0_cyc", 32'(c), 32'd40);

    // Asynchronous reset between clock edges while rst_out=100.
    wait_out(3'b100, 40, c);
    check_eq("areset_pre_cyc", 32'(c), 32'd16);
    #2 reset = 1'b1;
    #1;
    check_eq("areset_out", 32'(rst_out), 32'h7);
    check_eq("areset_idx", 32'(stage_idx), 32'd0);
    check_eq("areset_busy", 32'(busy), 32'd1);
    step(4);
    reset = 1'b0;

    // Minimal config: releases one edge after locked_s rises, no STAGE.
    step(4);
    check_eq("min_pre_rel", 32'(rst_out1), 32'd1);
    step(1);
    check_eq("min_rel", 32'(rst_out1), 32'd0);
    check_eq("min_idx", 32'(stage_idx1), 32'd1);
    check_eq("min_done", 32'(seq_done1), 32'd1);
    check_eq("min_busy", 32'(busy1), 32'd0);

    wait_out(3'b110, 100, c);
    check_eq("areset_rel0_cyc", 32'(c), 32'd31);
    wait_out(3'b000, 80, c);
    check_eq("areset_done", 32'(seq_done), 32'd1);

    soft1 = 1'b1;
    step(1);
    soft1 = 1'b0;
    check_eq("min_abort_out", 32'(rst_out1), 32'd1);
    check_eq("min_abort_busy", 32'(busy1), 32'd1);
    step(1);
    check_eq("min_hold_out", 32'(rst_out1), 32'd1);
    step(1);
    check_eq("min_rerel_out", 32'(rst_out1), 32'd0);
    check_eq("min_rerel_done", 32'(seq_done1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
